// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI TMDS 8b/10b encoder for one video channel with running-disparity DC balance
module tmds_encoder #(
  parameter int PIPE_OUT = 1
) (
  input  logic       clk_par,
  input  logic       srst,
  input  logic       de,
  input  logic [7:0] d,
  input  logic [1:0] c,
  output logic [9:0] q,
  output logic [4:0] disp
);
  localparam logic [9:0] TOK_00 = 10'b1101010100;
  logic [7:0] dg;
  logic [3:0] n1d, n1q;
  logic use_xnor, de1, ca, cb;
  logic [8:0] qm_n, qm;
  logic [1:0] c1;
  logic signed [4:0] cnt, cnt_n, diff;
  logic [9:0] q2, q2_n, tok;
  // gating d keeps X on an idle bus out of the transition-minimised word
  assign dg = de ? d : 8'h00;
  always_comb begin
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, dg[i]};
    use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !dg[0]);
    qm_n = '0;
    qm_n[0] = dg[0];
    for (int i = 1; i < 8; i++) qm_n[i] = use_xnor ? ~(qm_n[i-1] ^ dg[i]) : (qm_n[i-1] ^ dg[i]);
    qm_n[8] = !use_xnor;
  end
  always_comb begin
    n1q = 4'd0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, qm[i]};
    diff = {n1q, 1'b0} - 5'd8;
    ca = (cnt == 5'sd0) || (diff == 5'sd0);
    cb = (cnt > 5'sd0 && diff > 5'sd0) || (cnt < 5'sd0 && diff < 5'sd0);
    tok = c1[1] ? (c1[0] ? 10'b1010101011 : 10'b0101010100)
                : (c1[0] ? 10'b0010101011 : TOK_00);
    q2_n = !de1 ? tok
         : ca ? {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]}
         : cb ? {1'b1, qm[8], ~qm[7:0]}
         : {1'b0, qm[8], qm[7:0]};
    cnt_n = !de1 ? 5'sd0
          : ca ? cnt + (qm[8] ? diff : -diff)
          : cb ? cnt + {3'b000, qm[8], 1'b0} - diff
          : cnt + diff - {3'b000, ~qm[8], 1'b0};
  end
  always_ff @(posedge clk_par) begin
    if (srst) begin
      qm  <= '0;
      de1 <= 1'b0;
      c1  <= 2'b00;
      q2  <= TOK_00;
      cnt <= 5'sd0;
    end else begin
      qm  <= qm_n;
      de1 <= de;
      c1  <= c;
      q2  <= q2_n;
      cnt <= cnt_n;
    end
  end
  if (PIPE_OUT != 0) begin : g_out
    always_ff @(posedge clk_par) begin
      if (srst) begin
        q    <= TOK_00;
        disp <= 5'd0;
      end else begin
        q    <= q2;
        disp <= cnt;
      end
    end
  end else begin : g_comb
    assign q    = q2;
    assign disp = cnt;
  end
endmodule
